rotary_encoder_multi: RTL and testbench

//  Multi-channel incremental rotary encoder front-end with full 4x quadrature decoding.
//  Per channel: debounce, Gray-code tracking, one count per detent, invalid-transition detection.

---
 rtl/rotary_encoder_multi_if.sv | 26 ++
 rtl/rotary_encoder_multi.sv | 117 +++++++++++
 tb/tb_rotary_encoder_multi.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotary_encoder_multi_if.sv
// rotary_encoder_multi_if: encoder pins, per-channel load/clear controls and counter outputs.
interface rotary_encoder_multi_if #(
    parameter int NUM_CH       = 4,
    parameter int COUNTER_BITS = 8
);
    logic [NUM_CH-1:0]              encoder_clk;
    logic [NUM_CH-1:0]              encoder_dt;
    logic [NUM_CH-1:0]              encoder_sw;
    logic [NUM_CH-1:0]              counter_init;
    logic [NUM_CH*COUNTER_BITS-1:0] counter_in;
    logic [NUM_CH-1:0]              err_clr;
    logic [NUM_CH*COUNTER_BITS-1:0] counter_out;
    logic [NUM_CH-1:0]              counter_changed;
    logic [NUM_CH-1:0]              sw_pressed;
    logic [NUM_CH-1:0]              err_flag;

    modport master (
        output encoder_clk, encoder_dt, encoder_sw, counter_init, counter_in, err_clr,
        input  counter_out, counter_changed, sw_pressed, err_flag
    );

    modport slave (
        input  encoder_clk, encoder_dt, encoder_sw, counter_init, counter_in, err_clr,
        output counter_out, counter_changed, sw_pressed, err_flag
    );
endinterface

// File: rtl/rotary_encoder_multi.sv
// rotary_encoder_multi: multi-channel 4x quadrature encoder front-end with debounce, bounded counters and load.
// Defining ROTARY_ENCODER_ACCEL_EN adds a per-channel step accelerator.
module rotary_encoder_multi #(
    parameter int NUM_CH               = 4,
    parameter int COUNTER_BITS         = 8,
    parameter int DEBOUNCE_DELAY       = 100000,
    parameter int COUNTER_CLK_DECREASE = 1,
    parameter int STEP                 = 1,
    parameter int WRAP                 = 0,
    parameter int ACCEL_WINDOW         = 50000,
    parameter int ACCEL_MULT           = 4
) (
    input logic clk,
    input logic reset,
    rotary_encoder_multi_if.slave bus
);
    localparam int DBW = $clog2(DEBOUNCE_DELAY + 1);
    localparam int W = COUNTER_BITS + 32;
    localparam logic [W-1:0] MAXV = {32'd0, {COUNTER_BITS{1'b1}}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [2:0] pins, meta, sync, deb;
        logic [1:0] s, p;
        logic signed [3:0] acc, acc_nx;
        logic fwd, rev, bad, detent, step_up, step_dn, err;
        logic inc, dec, load, chg;
        logic [COUNTER_BITS-1:0] cnt_q, cnt_nx, ld, up_v, dn_v;
        logic [W-1:0] d, sum, dif;

        // bit 2 = switch, bit 1 = A (clk pin), bit 0 = B (dt pin)
        assign pins = {bus.encoder_sw[i], bus.encoder_clk[i], bus.encoder_dt[i]};

        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                meta <= '1;
                sync <= '1;
            end else begin
                meta <= pins;
                sync <= meta;
            end

        for (genvar j = 0; j < 3; j++) begin : g_db
            logic [DBW-1:0] cnt;
            logic q;
            always_ff @(posedge clk or posedge reset)
                if (reset) begin
                    cnt <= '0;
                    q   <= 1'b1;
                end else if (sync[j] == q) cnt <= '0;
                else if (cnt == DBW'(DEBOUNCE_DELAY - 1)) begin
                    cnt <= '0;
                    q   <= sync[j];
                end else cnt <= cnt + 1'b1;
            assign deb[j] = q;
        end

        assign s      = deb[1:0];
        assign fwd    = {p, s} == 4'b0010 || {p, s} == 4'b1011 || {p, s} == 4'b1101 || {p, s} == 4'b0100;
        assign rev    = {s, p} == 4'b0010 || {s, p} == 4'b1011 || {s, p} == 4'b1101 || {s, p} == 4'b0100;
        assign bad    = (s ^ p) == 2'b11;
        assign detent = (fwd | rev) && s == 2'b11;
        assign acc_nx = fwd ? (acc == 4'sd4 ? acc : acc + 4'sd1)
                      : rev ? (acc == -4'sd4 ? acc : acc - 4'sd1) : acc;

        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                p       <= 2'b11;
                acc     <= '0;
                step_up <= 1'b0;
                step_dn <= 1'b0;
                err     <= 1'b0;
            end else begin
                p       <= s;
                step_up <= detent && acc_nx == 4'sd4;
                step_dn <= detent && acc_nx == -4'sd4;
                acc     <= (bad || detent) ? '0 : acc_nx;
                err     <= bad | (err & ~bus.err_clr[i]);
            end

`ifdef ROTARY_ENCODER_ACCEL_EN
        localparam int TW = $clog2(ACCEL_WINDOW + 1);
        logic [TW-1:0] tmr;
        always_ff @(posedge clk or posedge reset)
            if (reset) tmr <= TW'(ACCEL_WINDOW);
            else if (step_up | step_dn) tmr <= '0;
            else if (tmr != TW'(ACCEL_WINDOW)) tmr <= tmr + 1'b1;
        assign d = tmr < TW'(ACCEL_WINDOW) ? W'(STEP * ACCEL_MULT) : W'(STEP);
`else
        assign d = W'(STEP);
`endif

        // step_up is the clk-leading (A-first) direction
        assign inc    = COUNTER_CLK_DECREASE != 0 ? step_dn : step_up;
        assign dec    = COUNTER_CLK_DECREASE != 0 ? step_up : step_dn;
        assign ld     = bus.counter_in[i*COUNTER_BITS +: COUNTER_BITS];
        assign load   = bus.counter_init[i] | ~deb[2];
        assign sum    = {32'd0, cnt_q} + d;
        assign dif    = {32'd0, cnt_q} - d;
        assign up_v   = (WRAP == 0 && sum > MAXV) ? '1 : sum[COUNTER_BITS-1:0];
        assign dn_v   = (WRAP == 0 && d > {32'd0, cnt_q}) ? '0 : dif[COUNTER_BITS-1:0];
        assign cnt_nx = load ? ld : inc ? up_v : dec ? dn_v : cnt_q;

        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                cnt_q <= '0;
                chg   <= 1'b0;
            end else begin
                cnt_q <= cnt_nx;
                chg   <= cnt_nx != cnt_q;
            end

        assign bus.counter_out[i*COUNTER_BITS +: COUNTER_BITS] = cnt_q;
        assign bus.counter_changed[i] = chg;
        assign bus.sw_pressed[i]      = ~deb[2];
        assign bus.err_flag[i]        = err;
    end
endmodule

// File: tb/tb_rotary_encoder_multi.sv
// tb_rotary_encoder_multi: scoreboard bench driving a saturating and a wrapping instance with identical stimulus.
module tb_rotary_encoder_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] enc_clk = '1, enc_dt = '1, enc_sw = '1, init = '0, clr = '0;
    logic [15:0] cin = '0;
    logic [15:0] cnt [2];
    logic [1:0] chg [2], sw [2], err [2];
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    int m [2][2];
    int checks = 0;
    int errors = 0;
`ifdef ROTARY_ENCODER_ACCEL_EN
    localparam int AMUL = 4;
`else
    localparam int AMUL = 1;
`endif

    rotary_encoder_multi_if #(.NUM_CH(2), .COUNTER_BITS(8)) bs ();
    rotary_encoder_multi_if #(.NUM_CH(2), .COUNTER_BITS(8)) bw ();

    assign bs.encoder_clk = enc_clk;  assign bw.encoder_clk = enc_clk;
    assign bs.encoder_dt = enc_dt;    assign bw.encoder_dt = enc_dt;
    assign bs.encoder_sw = enc_sw;    assign bw.encoder_sw = enc_sw;
    assign bs.counter_init = init;    assign bw.counter_init = init;
    assign bs.counter_in = cin;       assign bw.counter_in = cin;
    assign bs.err_clr = clr;          assign bw.err_clr = clr;
    assign cnt[0] = bs.counter_out;   assign cnt[1] = bw.counter_out;
    assign chg[0] = bs.counter_changed; assign chg[1] = bw.counter_changed;
    assign sw[0] = bs.sw_pressed;     assign sw[1] = bw.sw_pressed;
    assign err[0] = bs.err_flag;      assign err[1] = bw.err_flag;

    rotary_encoder_multi #(
        .NUM_CH(2), .COUNTER_BITS(8), .DEBOUNCE_DELAY(4), .COUNTER_CLK_DECREASE(1),
        .STEP(1), .WRAP(0), .ACCEL_WINDOW(100), .ACCEL_MULT(4)
    ) dut_s (.clk(clk), .reset(rst), .bus(bs));

    rotary_encoder_multi #(
        .NUM_CH(2), .COUNTER_BITS(8), .DEBOUNCE_DELAY(4), .COUNTER_CLK_DECREASE(1),
        .STEP(1), .WRAP(1), .ACCEL_WINDOW(100), .ACCEL_MULT(4)
    ) dut_w (.clk(clk), .reset(rst), .bus(bw));

    always #5 clk = ~clk;

    // Scoreboard: every counter_changed pulse must match the oldest expected {ch, value}
    always @(negedge clk)
        if (!rst)
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++)
                    if (chg[d][c]) begin
                        logic [8:0] e;
                        checks++;
                        if (qsize(d) == 0) begin
                            errors++;
                            $display("FAIL pulse dut%0d ch%0d: unexpected pulse, counter %0d", d, c, cnt[d][c*8 +: 8]);
                        end else begin
                            if (d == 0) e = q0.pop_front();
                            else e = q1.pop_front();
                            if (e !== {c[0], cnt[d][c*8 +: 8]}) begin
                                errors++;
                                $display("FAIL pulse dut%0d: got ch%0d=%0d, need ch%0d=%0d", d, c, cnt[d][c*8 +: 8], e[8], e[7:0]);
                            end
                        end
                    end

    function automatic int qsize(input int d);
        return d == 0 ? q0.size() : q1.size();
    endfunction

    function automatic int nxt(input int c, input int delta, input int wrap);
        int r = c + delta;
        return wrap != 0 ? (r & 255) : (r > 255 ? 255 : (r < 0 ? 0 : r));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_one(input int d, input int ch, input int val);
        logic [8:0] e;
        e = {ch[0], val[7:0]};
        if (m[d][ch] != val) begin
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        m[d][ch] = val;
    endtask

    task automatic load(input int ch, input int val);
        for (int d = 0; d < 2; d++) set_one(d, ch, val);
        cin[ch*8 +: 8] = val[7:0];
        init[ch] = 1'b1;
        tick(1);
        init[ch] = 1'b0;
        tick(3);
    endtask

    // fwd: B-leading 11,10,00,01,11 (counts up); otherwise A-leading 11,01,00,10,11 (counts down)
    task automatic detent(input int ch, input bit fwd, input int delta, input bit counts);
        logic [7:0] seq;
        seq = fwd ? 8'b10_00_01_11 : 8'b01_00_10_11;
        if (counts)
            for (int d = 0; d < 2; d++) set_one(d, ch, nxt(m[d][ch], fwd ? delta : -delta, d));
        for (int k = 0; k < 4; k++) begin
            {enc_clk[ch], enc_dt[ch]} = seq[7 - 2*k -: 2];
            tick(10);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({cnt[d], chg[d], sw[d], err[d]} !== 22'd0) begin
                errors++;
                $display("FAIL reset dut%0d: cnt=%h chg=%b sw=%b err=%b, need all 0", d, cnt[d], chg[d], sw[d], err[d]);
            end
        end
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_direction;
        load(0, 5);
        load(1, 8'h33);
        detent(0, 1'b0, 1, 1'b1);
        tick(15);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (qsize(d) != 0) begin errors++; $display("FAIL dir_pending dut%0d: %0d pulses outstanding, need 0", d, qsize(d)); end
            checks++;
            if (cnt[d] !== 16'h3304) begin errors++; $display("FAIL dir_count dut%0d: got %h need 3304", d, cnt[d]); end
        end
    endtask

    task automatic test_saturate_wrap;
        load(0, 253);
        for (int n = 0; n < 3; n++) detent(0, 1'b1, 1, 1'b1);
        tick(15);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (qsize(d) != 0) begin errors++; $display("FAIL sat_pending dut%0d: %0d pulses outstanding, need 0", d, qsize(d)); end
        end
        checks++;
        if (cnt[0][7:0] !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d need 255", cnt[0][7:0]); end
        checks++;
        if (cnt[1][7:0] !== 8'd0) begin errors++; $display("FAIL wrap_count: got %0d need 0", cnt[1][7:0]); end
    endtask

    task automatic test_glitch_err;
        for (int g = 0; g < 3; g++) begin
            enc_clk[0] = 1'b0;
            tick(3);
            enc_clk[0] = 1'b1;
            tick(8);
        end
        tick(10);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (err[d] !== 2'b00 || cnt[d][7:0] !== 8'(m[d][0])) begin
                errors++;
                $display("FAIL glitch dut%0d: err=%b cnt=%0d, need err=00 cnt=%0d", d, err[d], cnt[d][7:0], m[d][0]);
            end
        end
        {enc_clk[0], enc_dt[0]} = 2'b00;
        tick(15);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (err[d] !== 2'b01) begin errors++; $display("FAIL err_set dut%0d: got %b need 01", d, err[d]); end
        end
        {enc_clk[0], enc_dt[0]} = 2'b10;
        tick(10);
        {enc_clk[0], enc_dt[0]} = 2'b11;
        tick(15);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (err[d] !== 2'b01 || cnt[d][7:0] !== 8'(m[d][0]) || qsize(d) != 0) begin
                errors++;
                $display("FAIL err_nocount dut%0d: err=%b cnt=%0d pending=%0d, need 01/%0d/0", d, err[d], cnt[d][7:0], qsize(d), m[d][0]);
            end
        end
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        tick(1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (err[d] !== 2'b00) begin errors++; $display("FAIL err_clr dut%0d: got %b need 00", d, err[d]); end
        end
    endtask

    task automatic test_half;
        {enc_clk[0], enc_dt[0]} = 2'b10; tick(10);
        {enc_clk[0], enc_dt[0]} = 2'b00; tick(10);
        {enc_clk[0], enc_dt[0]} = 2'b10; tick(10);
        {enc_clk[0], enc_dt[0]} = 2'b11; tick(20);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cnt[d] !== {8'(m[d][1]), 8'(m[d][0])} || err[d] !== 2'b00 || qsize(d) != 0) begin
                errors++;
                $display("FAIL half dut%0d: cnt=%h err=%b pending=%0d, need cnt=%h err=00", d, cnt[d], err[d], qsize(d), {8'(m[d][1]), 8'(m[d][0])});
            end
        end
    endtask

    task automatic test_load_priority;
        {enc_clk[1], enc_dt[1]} = 2'b10; tick(10);
        {enc_clk[1], enc_dt[1]} = 2'b00; tick(10);
        {enc_clk[1], enc_dt[1]} = 2'b01; tick(10);
        for (int d = 0; d < 2; d++) set_one(d, 1, 8'h80);
        cin[15:8] = 8'h80;
        init[1] = 1'b1;
        {enc_clk[1], enc_dt[1]} = 2'b11;
        tick(25);
        init[1] = 1'b0;
        tick(15);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cnt[d][15:8] !== 8'h80 || qsize(d) != 0) begin
                errors++;
                $display("FAIL load_win dut%0d: got %h pending=%0d, need 80", d, cnt[d][15:8], qsize(d));
            end
        end
        for (int d = 0; d < 2; d++) set_one(d, 1, 8'h42);
        cin[15:8] = 8'h42;
        enc_sw[1] = 1'b0;
        tick(15);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (sw[d] !== 2'b10 || cnt[d][15:8] !== 8'h42) begin
                errors++;
                $display("FAIL sw_press dut%0d: sw=%b cnt=%h, need sw=10 cnt=42", d, sw[d], cnt[d][15:8]);
            end
        end
        detent(1, 1'b1, 1, 1'b0);
        tick(15);
        enc_sw[1] = 1'b1;
        tick(15);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (sw[d] !== 2'b00 || cnt[d][15:8] !== 8'h42 || qsize(d) != 0) begin
                errors++;
                $display("FAIL sw_hold dut%0d: sw=%b cnt=%h pending=%0d, need sw=00 cnt=42", d, sw[d], cnt[d][15:8], qsize(d));
            end
        end
    endtask

    task automatic test_accel;
        load(0, 10);
        tick(150);
        detent(0, 1'b1, 1, 1'b1);
        detent(0, 1'b1, AMUL, 1'b1);
        detent(0, 1'b1, AMUL, 1'b1);
        tick(300);
        detent(0, 1'b1, 1, 1'b1);
        tick(15);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cnt[d][7:0] !== 8'(10 + 1 + 2 * AMUL + 1) || qsize(d) != 0) begin
                errors++;
                $display("FAIL accel dut%0d: got %0d pending=%0d, need %0d", d, cnt[d][7:0], qsize(d), 10 + 2 + 2 * AMUL);
            end
        end
    endtask

    task automatic test_reset_mid;
        {enc_clk[0], enc_dt[0]} = 2'b10; tick(10);
        {enc_clk[0], enc_dt[0]} = 2'b00; tick(3);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({cnt[d], chg[d], sw[d], err[d]} !== 22'd0) begin
                errors++;
                $display("FAIL reset_mid dut%0d: cnt=%h chg=%b sw=%b err=%b, need all 0", d, cnt[d], chg[d], sw[d], err[d]);
            end
        end
        {enc_clk[0], enc_dt[0]} = 2'b11;
        tick(5);
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) m[d][c] = 0;
        rst = 1'b0;
        tick(15);
        detent(0, 1'b1, 1, 1'b1);
        tick(15);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cnt[d] !== 16'h0001 || err[d] !== 2'b00 || qsize(d) != 0) begin
                errors++;
                $display("FAIL restart dut%0d: cnt=%h err=%b pending=%0d, need cnt=0001", d, cnt[d], err[d], qsize(d));
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) m[d][c] = 0;
        test_reset;
        test_direction;
        test_saturate_wrap;
        test_glitch_err;
        test_half;
        test_load_priority;
        test_accel;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
